// File: rtl/nios_loader_pkg.sv
// rtl/nios_loader_pkg.sv - shared types, constants and lane helpers for the stream memory loader
package nios_loader_pkg;

    localparam int RAM_ADDR_W = 10;
    localparam int DATA_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_VRD     = 3'd3,
        ST_VCHK    = 3'd4,
        ST_DONE    = 3'd5
    } state_e;

    // n valid low lanes; 0 and 4 both mean a full word
    function automatic logic [3:0] lanemask(input logic [2:0] n);
        logic [3:0] m;
        case (n)
            3'd1:    m = 4'b0001;
            3'd2:    m = 4'b0011;
            3'd3:    m = 4'b0111;
            default: m = 4'b1111;
        endcase
        return m;
    endfunction

    function automatic logic [DATA_W-1:0] expand_mask(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

endpackage

// File: rtl/nios_stream_mem_loader_if.sv
// rtl/nios_stream_mem_loader_if.sv - on-chip RAM slave port driven by the loader
interface nios_stream_mem_loader_if
    import nios_loader_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W
);
    logic [ADDR_W-1:0] address;
    logic [3:0]        byteenable;
    logic              chipselect;
    logic              write;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              clken;

    modport master (
        output address, byteenable, chipselect, write, writedata, clken,
        input  readdata
    );

    modport slave (
        input  address, byteenable, chipselect, write, writedata, clken,
        output readdata
    );
endinterface

// File: rtl/nios_byte_packer.sv
// rtl/nios_byte_packer.sv - little-endian byte-to-word packer with lane valid mask
module nios_byte_packer
    import nios_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              accept_i,
    input  logic [7:0]        byte_i,
    input  logic              clear_i,
    output logic [DATA_W-1:0] word_o,
    output logic [3:0]        mask_o,
    output logic              full_o
);

    logic [1:0]        idx_q,  idx_d;
    logic [DATA_W-1:0] word_q, word_d;
    logic [3:0]        mask_q, mask_d;

    // clearing zeroes the word so lanes never filled read back as 0
    always_comb begin
        idx_d  = idx_q;
        word_d = word_q;
        mask_d = mask_q;
        if (clear_i) begin
            idx_d  = '0;
            word_d = '0;
            mask_d = '0;
        end else if (accept_i) begin
            word_d[{idx_q, 3'b000} +: 8] = byte_i;
            mask_d[idx_q]                = 1'b1;
            idx_d                        = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q  <= '0;
            word_q <= '0;
            mask_q <= '0;
        end else begin
            idx_q  <= idx_d;
            word_q <= word_d;
            mask_q <= mask_d;
        end
    end

    assign word_o = word_q;
    assign mask_o = mask_q;
    assign full_o = (idx_q == 2'd3);

endmodule

// File: rtl/nios_stream_mem_loader.sv
// rtl/nios_stream_mem_loader.sv - byte stream to on-chip RAM loader with checksum readback verify
module nios_stream_mem_loader
    import nios_loader_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int LEN_W  = 12
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [LEN_W-1:0]          len_bytes,
    input  logic                      verify_en,
    input  logic [7:0]                in_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    nios_stream_mem_loader_if.master  ram,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [DATA_W-1:0]         checksum
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [ADDR_W-1:0] base_q,  base_d;
    logic [LEN_W-1:0]  len_q,   len_d;
    logic [LEN_W-1:0]  rem_q,   rem_d;
    logic [LEN_W-1:0]  words_q, words_d;
    logic              verify_q, verify_d;
    logic [DATA_W-1:0] sum_q,   sum_d;
    logic [DATA_W-1:0] vsum_q,  vsum_d;
    logic              error_q, error_d;
    logic              clken_q;

    logic              pk_accept, pk_clear, pk_full;
    logic [DATA_W-1:0] pk_word;
    logic [3:0]        pk_mask;

    logic              cs, wr;
    logic [3:0]        be;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        lane_m;

    assign pk_accept = (state_q == ST_COLLECT) && in_valid;
    assign pk_clear  = (state_q == ST_IDLE) || (state_q == ST_WRITE);

    nios_byte_packer u_packer (
        .clk      (clk),
        .rst_n    (reset_n),
        .accept_i (pk_accept),
        .byte_i   (in_data),
        .clear_i  (pk_clear),
        .word_o   (pk_word),
        .mask_o   (pk_mask),
        .full_o   (pk_full)
    );

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        base_d   = base_q;
        len_d    = len_q;
        rem_d    = rem_q;
        words_d  = words_q;
        verify_d = verify_q;
        sum_d    = sum_q;
        vsum_d   = vsum_q;
        error_d  = error_q;
        in_ready = 1'b0;
        done     = 1'b0;
        cs       = 1'b0;
        wr       = 1'b0;
        be       = 4'h0;
        wdata    = '0;
        lane_m   = 4'hF;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    addr_d   = base_addr;
                    len_d    = len_bytes;
                    rem_d    = len_bytes;
                    verify_d = verify_en;
                    sum_d    = '0;
                    vsum_d   = '0;
                    error_d  = 1'b0;
                    state_d  = (len_bytes == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    rem_d = rem_q - 1'b1;
                    if (pk_full || rem_q == LEN_W'(1)) begin
                        state_d = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                cs     = 1'b1;
                wr     = 1'b1;
                be     = pk_mask;
                wdata  = pk_word;
                sum_d  = sum_q + pk_word;
                addr_d = addr_q + 1'b1;
                if (rem_q != '0) begin
                    state_d = ST_COLLECT;
                end else if (verify_q) begin
                    // restart from base for the readback pass
                    addr_d  = base_q;
                    words_d = LEN_W'(({1'b0, len_q} + (LEN_W + 1)'(3)) >> 2);
                    state_d = ST_VRD;
                end else begin
                    state_d = ST_DONE;
                end
            end
            ST_VRD: begin
                cs      = 1'b1;
                be      = 4'hF;
                state_d = ST_VCHK;
            end
            ST_VCHK: begin
                // only the final word carries a partial lane count
                if (words_q == LEN_W'(1)) begin
                    lane_m = lanemask({1'b0, len_q[1:0]});
                end
                vsum_d  = vsum_q + (ram.readdata & expand_mask(lane_m));
                addr_d  = addr_q + 1'b1;
                words_d = words_q - 1'b1;
                state_d = (words_q == LEN_W'(1)) ? ST_DONE : ST_VRD;
            end
            ST_DONE: begin
                done    = 1'b1;
                error_d = verify_q && (vsum_q != sum_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            base_q   <= '0;
            len_q    <= '0;
            rem_q    <= '0;
            words_q  <= '0;
            verify_q <= 1'b0;
            sum_q    <= '0;
            vsum_q   <= '0;
            error_q  <= 1'b0;
            clken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            base_q   <= base_d;
            len_q    <= len_d;
            rem_q    <= rem_d;
            words_q  <= words_d;
            verify_q <= verify_d;
            sum_q    <= sum_d;
            vsum_q   <= vsum_d;
            error_q  <= error_d;
            clken_q  <= 1'b1;
        end
    end

    assign ram.address    = cs ? addr_q : '0;
    assign ram.byteenable = be;
    assign ram.chipselect = cs;
    assign ram.write      = wr;
    assign ram.writedata  = wdata;
    assign ram.clken      = clken_q;

    assign busy     = (state_q != ST_IDLE) && (state_q != ST_DONE);
    assign error    = error_q;
    assign checksum = sum_q;

endmodule

// File: tb/tb_nios_stream_mem_loader.sv
// tb/tb_nios_stream_mem_loader.sv - self-checking bench for the stream memory loader
module tb_nios_stream_mem_loader;
    import nios_loader_pkg::*;

    localparam int AW = 10;
    localparam int LW = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [LW-1:0] len_bytes = '0;
    logic          verify_en = 1'b0;
    logic [7:0]    in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready, busy, done, error;
    logic [31:0]   checksum;

    nios_stream_mem_loader_if #(.ADDR_W(AW)) ram_if ();

    nios_stream_mem_loader #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .base_addr (base_addr),
        .len_bytes (len_bytes),
        .verify_en (verify_en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ram       (ram_if),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .checksum  (checksum)
    );

    always #5 clk = ~clk;

    // RAM model: byte-enabled writes, 1-cycle read latency, optional bit-0 flip at addr 0
    logic [31:0] mem [0:1023];
    logic [31:0] rd_q = '0;
    logic        corrupt = 1'b0;

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int l = 0; l < 4; l++) if (be[l]) r[8*l +: 8] = nw[8*l +: 8];
        return r;
    endfunction

    always @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5A5A5;
        end else if (ram_if.clken && ram_if.chipselect) begin
            if (ram_if.write)
                mem[ram_if.address] <= merge(mem[ram_if.address], ram_if.writedata, ram_if.byteenable)
                                       ^ ((corrupt && ram_if.address == 10'd0) ? 32'h1 : 32'h0);
            else
                rd_q <= mem[ram_if.address];
        end
    end
    assign ram_if.readdata = rd_q;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    typedef struct {
        logic [9:0]  a;
        logic [3:0]  be;
        logic [31:0] d;
    } wr_t;

    wr_t        exp_wr[$];
    logic [9:0] exp_rd[$];
    wr_t        mon_w;
    logic [9:0] mon_a;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    int         last_wr_cyc = 0;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // scoreboard: every RAM access pops the next expected one
    initial forever begin
        @(negedge clk);
        if (ram_if.chipselect && ram_if.write) begin
            if (exp_wr.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: addr %h data %h, none expected", ram_if.address, ram_if.writedata);
            end else begin
                mon_w = exp_wr.pop_front();
                check("wr_addr", 32'(ram_if.address), 32'(mon_w.a));
                check("wr_be", 32'(ram_if.byteenable), 32'(mon_w.be));
                check("wr_data", ram_if.writedata, mon_w.d);
            end
            last_wr_cyc = cyc;
        end
        if (ram_if.chipselect && !ram_if.write) begin
            if (exp_rd.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_read: addr %h, none expected", ram_if.address);
            end else begin
                mon_a = exp_rd.pop_front();
                check("rd_addr", 32'(ram_if.address), 32'(mon_a));
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    typedef struct {
        logic [9:0]  base;
        logic [11:0] len;
        logic        verify;
        logic        corrupt;
        logic        gaps;
        logic        busy_start;
        logic [7:0]  b0;
        logic [7:0]  step;
        logic [31:0] exp_sum;
        logic        exp_err;
    } vec_t;

    vec_t vecs[7];

    task automatic run_vec(input vec_t v);
        logic [7:0]  bytes[$];
        logic [7:0]  b;
        logic [31:0] d;
        logic [3:0]  be;
        logic [9:0]  a;
        logic        acc;
        int          k, guard, d0, nwords;
        b = v.b0;
        for (int i = 0; i < int'(v.len); i++) begin
            bytes.push_back(b);
            b = b + v.step;
        end
        nwords = (int'(v.len) + 3) / 4;
        for (int w = 0; w < nwords; w++) begin
            d  = '0;
            be = '0;
            for (int l = 0; l < 4; l++) begin
                if (4*w + l < int'(v.len)) begin
                    d[8*l +: 8] = bytes[4*w + l];
                    be[l]       = 1'b1;
                end
            end
            a = v.base + 10'(w);
            exp_wr.push_back('{a, be, d});
            if (v.verify) exp_rd.push_back(a);
        end
        corrupt = v.corrupt;
        d0 = done_cnt;
        @(negedge clk);
        base_addr = v.base;
        len_bytes = v.len;
        verify_en = v.verify;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.len == 0) begin
            check("done_at_T+1", 32'(done), 32'd1);
            check("busy_len0", 32'(busy), 32'd0);
        end else begin
            check("busy_at_T+1", 32'(busy), 32'd1);
            check("in_ready_at_T+1", 32'(in_ready), 32'd1);
        end
        k = 0;
        guard = 0;
        while (k < int'(v.len) && guard < 2000) begin
            if (v.gaps && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
            end else begin
                in_valid = 1'b1;
                in_data  = bytes[k];
            end
            if (v.busy_start && k == 2) begin
                start     = 1'b1;
                base_addr = v.base + 10'd100;
            end else begin
                start = 1'b0;
            end
            acc = in_valid && in_ready;
            @(negedge clk);
            guard++;
            if (acc) k++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        guard = 0;
        while (done_cnt == d0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        repeat (2) @(negedge clk);
        check("done_count", 32'(done_cnt - d0), 32'd1);
        check("checksum", checksum, v.exp_sum);
        check("error", 32'(error), 32'(v.exp_err));
        check("busy_after_done", 32'(busy), 32'd0);
        check("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        if (!v.verify && v.len != 0)
            check("done_latency", 32'(done_cyc - last_wr_cyc), 32'd1);
        exp_wr.delete();
        exp_rd.delete();
        corrupt = 1'b0;
    endtask

    initial begin
        // base len vfy crp gap bst b0 step exp_sum err
        vecs[0] = '{10'd0,    12'd8,  1'b0, 1'b0, 1'b0, 1'b0, 8'h01, 8'h01, 32'h0C0A0806, 1'b0};
        vecs[1] = '{10'd5,    12'd5,  1'b0, 1'b0, 1'b0, 1'b0, 8'hAA, 8'h11, 32'hDDCCBC98, 1'b0};
        vecs[2] = '{10'd1023, 12'd8,  1'b1, 1'b0, 1'b0, 1'b0, 8'h10, 8'h01, 32'h2A282624, 1'b0};
        vecs[3] = '{10'd1023, 12'd8,  1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h01, 32'h2A282624, 1'b1};
        vecs[4] = '{10'd300,  12'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 32'h00000000, 1'b0};
        vecs[5] = '{10'd100,  12'd7,  1'b1, 1'b0, 1'b0, 1'b0, 8'h21, 8'h01, 32'h244A4846, 1'b0};
        vecs[6] = '{10'd200,  12'd12, 1'b1, 1'b0, 1'b1, 1'b1, 8'h40, 8'h01, 32'hD5D2CFCC, 1'b0};

        repeat (3) @(negedge clk);
        check("rst_clken", 32'(ram_if.clken), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_chipselect", 32'(ram_if.chipselect), 32'd0);
        check("rst_checksum", checksum, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("clken_after_rst", 32'(ram_if.clken), 32'd1);
        check("idle_done", 32'(done), 32'd0);

        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i]);
            if (vecs[i].corrupt) begin
                repeat (5) @(negedge clk);
                check("error_held", 32'(error), 32'd1);
            end
        end

        // reset mid-word: two of four bytes taken, then reset
        @(negedge clk);
        base_addr = 10'd50;
        len_bytes = 12'd4;
        verify_en = 1'b0;
        start     = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'h11;
        @(negedge clk);
        in_data = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        reset_n  = 1'b0;
        #1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        check("midrst_write", 32'(ram_if.write), 32'd0);
        check("midrst_chipselect", 32'(ram_if.chipselect), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_clken", 32'(ram_if.clken), 32'd0);
        check("midrst_checksum", checksum, 32'd0);
        check("midrst_address", 32'(ram_if.address), 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("midrst_clken_back", 32'(ram_if.clken), 32'd1);
        check("midrst_idle", 32'(busy), 32'd0);

        run_vec(vecs[6]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/nios_stream_mem_loader.md
# nios_stream_mem_loader

Upstream loader for the Nios II on-chip RAM slave (1024 × 32, single port, byte enables, 1-cycle read latency). It takes a byte stream, such as UART RX or JTAG FIFO, and packs it little-endian into 32-bit words. It writes those words into the RAM starting at a programmed word address. An optional verify pass reads the region back and compares checksums. It drives the RAM port directly and is muxed with the CPU data master only while `busy` is high.

## Interface
Parameters:
- `ADDR_W`, 10: RAM word-address width (1024 words).
- `LEN_W`, 12: byte-count width (max 4095 bytes).

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
- `clk`, in, 1: system clock, shared with the RAM.
- `reset_n`, in, 1: asynchronous active-low reset.
- `start`, in, 1: single-cycle command strobe, sampled in IDLE only.
- `base_addr`, in, ADDR_W: first word address, latched on `start`.
- `len_bytes`, in, LEN_W: byte count, latched on `start`.
- `verify_en`, in, 1: run a readback pass after the write pass; latched on `start`.
- `in_data`, in, 8: stream byte.
- `in_valid`, in, 1: stream byte valid.
- `in_ready`, out, 1: loader accepts a byte when `in_valid & in_ready`.
- `address`, out, ADDR_W: RAM address.
- `byteenable`, out, 4: RAM byte enables.
- `chipselect`, out, 1: RAM select.
- `write`, out, 1: RAM write strobe.
- `writedata`, out, 32: RAM write data.
- `readdata`, in, 32: RAM read data, valid 1 cycle after the read address.
- `clken`, out, 1: RAM clock enable; 0 in reset, 1 otherwise.
- `busy`, out, 1: high from the cycle after `start` is accepted until `done`.
- `done`, out, 1: one-cycle completion pulse.
- `error`, out, 1: verify mismatch; held until the next accepted `start`.
- `checksum`, out, 32: write-pass sum of masked words, mod 2^32.

## Operation
FSM states are IDLE, COLLECT, WRITE, VRD, VCHK and DONE.

- **IDLE**
  - `in_ready` is 0.
  - On `start`: latch `base_addr`, `len_bytes` and `verify_en`; clear the sums, `error` and the lane index.
  - If `len_bytes` = 0, go to DONE. Otherwise go to COLLECT.
  - `start` in any other state is ignored.
- **COLLECT**
  - `in_ready` is 1.
  - Each accepted byte goes into lane `idx` (byte 0 = bits 7:0) and sets `mask[idx]`. The remaining-byte count decrements and `idx` increments.
  - Go to WRITE after lane 3 is accepted or the last byte is accepted.
- **WRITE** (1 cycle)
  - Outputs: `in_ready` = 0, `chipselect` = `write` = 1, `byteenable` = mask, `writedata` = packed word.
  - Unmasked lanes of `writedata` are 0.
  - `checksum += writedata`. Address advances mod 2^ADDR_W (wrap 1023 → 0). Clear mask and `idx`.
  - Next state: COLLECT if bytes remain; otherwise VRD if verify is enabled; otherwise DONE.
- **VRD**
  - On entry from WRITE, the address is reloaded to base and the word count restarts.
  - Outputs: `chipselect` = 1, `write` = 0, `byteenable` = 4'hF.
  - Go to VCHK.
- **VCHK**
  - `vsum += readdata & lanemask(word)`. The lane mask is all-ones, except the final word, which is masked to `len_bytes` mod 4 lanes (0 means all four).
  - Address +1 with wrap.
  - Next state: VRD if words remain; otherwise DONE.
- **DONE**
  - `done` = 1. `error` = `verify & (vsum != checksum)`.
  - Go to IDLE. `busy` falls in the same cycle `done` rises.
- **Outputs outside WRITE/VRD/VCHK:** `chipselect`, `write`, `byteenable` and `writedata` are 0.
- **Word count:** ceil(`len_bytes`/4), computed as `(len_bytes + 3) >> 2`.

## Timing
- **Reset values:** all outputs 0, except that `clken` goes to 1 on the first clock after reset deassertion. State is IDLE. `checksum` = 0.
- **Reset mid-operation:** immediate return to IDLE. No partial word is written. `done` is not pulsed.
- **Start latency:** `start` at cycle T gives `busy` and `in_ready` high at T+1.
- **Write pass throughput:** with `in_valid` held high, each full word takes 4 accept cycles plus 1 WRITE cycle, i.e. 5 cycles per word. `in_valid` gaps stall COLLECT without limit.
- **Read pipeline:** the read address is presented in VRD and `readdata` is sampled in VCHK (1-cycle latency). Verify costs 2 cycles per word.
- **Done latency:** `done` fires the cycle after the final WRITE (no verify) or the final VCHK. With `len_bytes` = 0, `done` fires at T+1.
- **Simultaneous events:** `start` coincident with `done` is ignored, because the FSM is not yet in IDLE.

## Structure
- **Package `nios_loader_pkg`:** state encoding localparams, `ADDR_W`/`DATA_W` constants, and the `lanemask(n)` function (n = 1..4 → 4'b0001..4'b1111).
- **Sub-module `nios_byte_packer`:**
  - Contains the lane index, the 32-bit shift/insert register and the mask.
  - Interface: `accept`, `byte`, `clear` in; `word`, `mask`, `full` out.
  - FSM, counters and checksums stay in the top module.

## Test plan
- **Aligned load:** base 0, len 8, bytes 01..08, no verify → writes at addr 0 `32'h04030201` (be F) and addr 1 `32'h08070605` (be F); `checksum` = `32'h0C0A0806`; one `done` pulse, `error` = 0.
- **Partial tail:** len 5, bytes AA BB CC DD EE → second write at base+1 with be 4'b0001 and data `32'h000000EE`.
- **Wrap with verify:** base 1023, len 8, verify on, RAM model faithful → writes at 1023 then 0; reads at 1023, 0; `error` = 0.
- **Corruption:** same as the previous case, but the model flips bit 0 of addr 0 before verify → `error` = 1 after `done`, held until the next `start`.
- **Zero length and busy:** len 0 → `done` at T+1 with no RAM access. A `start` pulsed during a load is ignored: addresses are unchanged and only one `done` occurs.
- **Reset and stall:** `reset_n` low after 2 of 4 bytes → no write issued, all outputs 0. Random `in_valid` gaps → identical RAM contents.
